// File: rtl/ddram_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddram_rom_arbiter
// Brief    : Shares the DDR3 Avalon port between the HPS ROM download writer
//            (16-bit words) and the core ROM fetch reader (64-bit lines).
//            Optional one-line read cache enabled by DDRAM_RDCACHE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ddram_rom_arbiter #(
    parameter logic [28:0] BASE_ADDR = 29'h0600000,
    parameter int          ADDR_W    = 25
) (
    input  logic              clk_sys,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] wraddr,
    input  logic [15:0]       din,
    input  logic              we_req,
    output logic              we_ack,

    input  logic [ADDR_W-1:0] rdaddr,
    output logic [63:0]       dout,
    input  logic              rd_req,
    output logic              rd_ack,

    input  logic              DDRAM_BUSY,
    output logic [7:0]        DDRAM_BURSTCNT,
    output logic [28:0]       DDRAM_ADDR,
    input  logic [63:0]       DDRAM_DOUT,
    input  logic              DDRAM_DOUT_READY,
    output logic              DDRAM_RD,
    output logic [63:0]       DDRAM_DIN,
    output logic [7:0]        DDRAM_BE,
    output logic              DDRAM_WE
);

    localparam int c_line_w = ADDR_W - 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WR      = 2'd1,
        S_RD      = 2'd2,
        S_RD_WAIT = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_we_ack;
    logic                r_rd_ack;
    logic [63:0]         r_dout;
    logic                r_ddr_rd;
    logic                r_ddr_we;
    logic [28:0]         r_ddr_addr;
    logic [63:0]         r_ddr_din;
    logic [7:0]          r_ddr_be;

    logic                w_wr_pend;
    logic                w_rd_pend;
    logic [c_line_w-1:0] w_wr_line;
    logic [c_line_w-1:0] w_rd_line;
    logic [28:0]         w_wr_ddr_addr;
    logic [28:0]         w_rd_ddr_addr;
    logic [7:0]          w_wr_be;
    logic                w_cache_hit;
    logic [63:0]         w_cache_data;
    logic                w_unused_bits;

    assign w_wr_pend     = we_req ^ r_we_ack;
    assign w_rd_pend     = rd_req ^ r_rd_ack;
    assign w_wr_line     = wraddr[ADDR_W-1:3];
    assign w_rd_line     = rdaddr[ADDR_W-1:3];
    // Line addresses wrap modulo 2^29 after the base offset is applied.
    assign w_wr_ddr_addr = BASE_ADDR + 29'(w_wr_line);
    assign w_rd_ddr_addr = BASE_ADDR + 29'(w_rd_line);
    assign w_wr_be       = 8'b0000_0011 << {wraddr[2:1], 1'b0};
    assign w_unused_bits = &{1'b0, wraddr[0], rdaddr[2:0]};

    assign we_ack         = r_we_ack;
    assign rd_ack         = r_rd_ack;
    assign dout           = r_dout;
    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_ADDR     = r_ddr_addr;
    assign DDRAM_RD       = r_ddr_rd;
    assign DDRAM_DIN      = r_ddr_din;
    assign DDRAM_BE       = r_ddr_be;
    assign DDRAM_WE       = r_ddr_we;

`ifdef DDRAM_RDCACHE_EN
    logic [c_line_w-1:0] r_cache_tag;
    logic [63:0]         r_cache_data;
    logic                r_cache_valid;

    assign w_cache_hit  = r_cache_valid && (r_cache_tag == w_rd_line);
    assign w_cache_data = r_cache_data;

    // A write to the cached line invalidates it as the write leaves IDLE.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_cache_tag   <= '0;
            r_cache_data  <= 64'd0;
            r_cache_valid <= 1'b0;
        end else if (r_state == S_IDLE && w_wr_pend) begin
            if (r_cache_tag == w_wr_line) begin
                r_cache_valid <= 1'b0;
            end
        end else if (r_state == S_RD_WAIT && DDRAM_DOUT_READY) begin
            r_cache_tag   <= w_rd_line;
            r_cache_data  <= DDRAM_DOUT;
            r_cache_valid <= 1'b1;
        end
    end
`else
    assign w_cache_hit  = 1'b0;
    assign w_cache_data = 64'd0;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_we_ack   <= 1'b0;
            r_rd_ack   <= 1'b0;
            r_dout     <= 64'd0;
            r_ddr_rd   <= 1'b0;
            r_ddr_we   <= 1'b0;
            r_ddr_addr <= 29'd0;
            r_ddr_din  <= 64'd0;
            r_ddr_be   <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Writes win: the ROM download must never be starved.
                    if (w_wr_pend) begin
                        r_ddr_addr <= w_wr_ddr_addr;
                        r_ddr_din  <= {4{din}};
                        r_ddr_be   <= w_wr_be;
                        r_ddr_we   <= 1'b1;
                        r_state    <= S_WR;
                    end else if (w_rd_pend) begin
                        if (w_cache_hit) begin
                            r_dout   <= w_cache_data;
                            r_rd_ack <= ~r_rd_ack;
                        end else begin
                            r_ddr_addr <= w_rd_ddr_addr;
                            r_ddr_rd   <= 1'b1;
                            r_state    <= S_RD;
                        end
                    end
                end
                S_WR: begin
                    if (!DDRAM_BUSY) begin
                        r_ddr_we <= 1'b0;
                        r_we_ack <= ~r_we_ack;
                        r_state  <= S_IDLE;
                    end
                end
                S_RD: begin
                    if (!DDRAM_BUSY) begin
                        r_ddr_rd <= 1'b0;
                        r_state  <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (DDRAM_DOUT_READY) begin
                        r_dout   <= DDRAM_DOUT;
                        r_rd_ack <= ~r_rd_ack;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/ddram_rom_arbiter.md
Name: ddram_rom_arbiter

Overview:
- Shares the single DDR3 Avalon-style port (DDRAM_*) between two requesters:
  - the HPS ROM download writer, 16-bit words;
  - the core's ROM fetch reader, 64-bit lines.
- Both requesters use toggle handshakes: a request is pending while req != ack.
- Sits between hps_io/download glue and Virtual_Toplevel on the clk_ram domain; this clock drives DDRAM_CLK.

Parameters:
- BASE_ADDR, 29'h0600000, 64-bit-word base of the ROM region in DDR3; added to every request address.
- ADDR_W, 25, byte-address width of both requester addresses.

Ports:
- clk_sys  in  1  sole clock; the instantiating level connects clk_ram.
- reset_n  in  1  asynchronous active-low reset.
- wraddr  in  ADDR_W  write byte address; bit 0 ignored.
- din  in  16  write data, already byte-swapped by the caller.
- we_req  in  1  write request toggle.
- we_ack  out  1  write acknowledge toggle.
- rdaddr  in  ADDR_W  read byte address; bits [2:0] ignored.
- dout  out  64  read line data.
- rd_req  in  1  read request toggle.
- rd_ack  out  1  read acknowledge toggle.
- DDRAM_BUSY  in  1  DDR3 wait-request.
- DDRAM_BURSTCNT  out  8  burst count.
- DDRAM_ADDR  out  29  64-bit-word address.
- DDRAM_DOUT  in  64  read data.
- DDRAM_DOUT_READY  in  1  read data valid.
- DDRAM_RD  out  1  read command.
- DDRAM_DIN  out  64  write data.
- DDRAM_BE  out  8  byte enables.
- DDRAM_WE  out  1  write command.

Behaviour:
- Reset values: we_ack=0, rd_ack=0, dout=0, DDRAM_RD=0, DDRAM_WE=0, DDRAM_ADDR=0, DDRAM_DIN=0, DDRAM_BE=0. DDRAM_BURSTCNT is constant 1.
- Pending flags: wr_pend = we_req ^ we_ack; rd_pend = rd_req ^ rd_ack. Requesters change address/data only while not pending.
- FSM states: IDLE, WR, RD, RD_WAIT.
- IDLE:
  - if wr_pend, go to WR; write has fixed priority over read.
  - else if rd_pend, go to RD.
  - Command registers load on the IDLE exit edge, so DDRAM_WE or DDRAM_RD rises 1 cycle after the pending flag is seen.
- WR command formation:
  - DDRAM_ADDR = BASE_ADDR + wraddr[ADDR_W-1:3].
  - DDRAM_DIN = {4{din}}.
  - DDRAM_BE = 8'b11 << (2*wraddr[2:1]).
  - DDRAM_WE held high until sampled with DDRAM_BUSY=0.
  - On that edge: WE drops, we_ack toggles, FSM returns to IDLE.
- RD command formation:
  - DDRAM_ADDR = BASE_ADDR + rdaddr[ADDR_W-1:3]; DDRAM_RD held until DDRAM_BUSY=0, then drops and FSM enters RD_WAIT.
  - RD_WAIT: on the first DDRAM_DOUT_READY, dout <= DDRAM_DOUT and rd_ack toggles in the same edge, then IDLE.
  - Any DOUT_READY outside RD_WAIT is ignored.
- Address arithmetic is modulo 2^29; wrap-around is not flagged.
- Simultaneous new wr_pend and rd_pend: write served first; read starts on the IDLE cycle after we_ack toggles.
- One transaction is in flight at a time. A new toggle on the owning requester during its own service is a protocol violation; no recovery is defined.
- Minimum latency, BUSY=0 throughout: write req toggle to ack toggle = 2 cycles. Read = 3 cycles plus DDR read latency.
- Reset mid-operation: FSM forced to IDLE, outputs to reset values. Both acks go to 0, so requesters must also clear req (FPGAGen glue zeros rom_wr at download start). Any DOUT_READY after reset is dropped.

Optional Feature:
- Macro: DDRAM_RDCACHE_EN.
- Defined: one-line read cache holds tag (line address), a 64-bit line and a valid bit.
  - A read whose line matches a valid tag completes from cache: rd_ack toggles and dout updates 1 cycle after the pending flag is seen, with no DDRAM_RD issued. This is checked in IDLE only when no write is pending.
  - Misses fill the cache on DOUT_READY.
  - A write whose line matches the tag clears valid.
  - Reset clears valid.
- Undefined: every read goes to DDR3; no extra registers.

Test Plan:
- Reset, then one write (wraddr=0x000006, din=0xA55A, BUSY=0) -> WE pulses 1 cycle, ADDR=0x0600000, BE=8'hC0, DIN=64'hA55AA55AA55AA55A, we_ack 0->1 two cycles after toggle.
- Read rdaddr=0x000108 with BUSY held 3 cycles, DOUT_READY 5 cycles later with 64'h0123456789ABCDEF -> RD high 4 cycles, ADDR=0x0600021, dout=64'h0123456789ABCDEF, rd_ack toggles same edge.
- we_req and rd_req toggled same cycle -> WE precedes RD, we_ack toggles before rd_ack, exactly one DDR command each.
- Assert reset_n=0 in RD_WAIT, release, then inject a stray DOUT_READY -> acks 0, RD/WE 0, dout unchanged 0, FSM in IDLE.
- With DDRAM_RDCACHE_EN: read 0x40 twice -> one DDRAM_RD, second rd_ack 1 cycle after toggle. Then write 0x42, read 0x40 again -> new DDRAM_RD issued.
- Back-to-back 64 writes streaming ROM with random BUSY -> each we_ack matches its we_req, DDR3 model memory equals written pattern.
